// File: rtl/keccak_arbiter.sv
// keccak_arbiter: shares one KECCAK permutation core between NUM_REQ requesters.
// Round-robin grant per message; each message runs clear -> absorb -> permute per block,
// then the finished core state is handed back to the owner.
// Optional watchdog on the permutation: define KECCAK_ARB_TIMEOUT_EN.
module keccak_arbiter #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned STATE_WIDTH = 1600,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [NUM_REQ-1:0]             REQ,
  output logic [NUM_REQ-1:0]             GNT,
  input  logic [NUM_REQ-1:0]             BLK_VALID,
  input  logic [NUM_REQ-1:0]             BLK_LAST,
  input  logic [NUM_REQ*STATE_WIDTH-1:0] BLK_DATA,
  output logic [NUM_REQ-1:0]             BLK_READY,
  output logic [NUM_REQ-1:0]             HASH_VALID,
  input  logic [NUM_REQ-1:0]             HASH_READY,
  output logic [STATE_WIDTH-1:0]         HASH_OUT,
  output logic                           ERROR,
  output logic                           K_RESETN,
  output logic                           K_ENABLE,
  output logic                           K_INIT,
  output logic [STATE_WIDTH-1:0]         K_M,
  input  logic                           K_DONE,
  input  logic [STATE_WIDTH-1:0]         K_OUT
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ABSORB,
    ST_PERM,
    ST_OUT
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] blk_ready_q;
  logic [NUM_REQ-1:0] hash_valid_q;
  logic               last_q;
  logic               k_resetn_q;
  logic               k_enable_q;
  logic               k_init_q;
  logic               error_q;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   rr_d;
  logic               hs_c;
  logic               abort_c;
  logic               tmo_c;

  // Round-robin pick: first asserted REQ at or after the pointer, wrapping.
  always_comb begin : rr_pick
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = (int'(rr_q) + k) % int'(NUM_REQ);
      if (!win_found && REQ[idx]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
    rr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
  end

  // Result handshake wins over a simultaneous REQ release; any other release aborts.
  always_comb begin
    hs_c    = (state_q == ST_OUT) && hash_valid_q[owner_q] && HASH_READY[owner_q];
    abort_c = (state_q != ST_IDLE) && !REQ[owner_q] && !hs_c;
  end

`ifdef KECCAK_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  // Watchdog trips on the PERM cycle that would be the TIMEOUT-th without K_DONE.
  always_comb begin
    tmo_c = (state_q == ST_PERM) && !K_DONE && (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // PERM cycle counter, cleared on every PERM entry.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (state_q == ST_ABSORB) begin
      cnt_q <= '0;
    end else if (state_q == ST_PERM) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;

  always_comb begin
    tmo_c          = 1'b0;
    unused_timeout = ^32'(TIMEOUT);
  end
`endif

  // Arbitration / sequencing FSM with registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      rr_q         <= '0;
      gnt_q        <= '0;
      blk_ready_q  <= '0;
      hash_valid_q <= '0;
      last_q       <= 1'b0;
      k_resetn_q   <= 1'b0;
      k_enable_q   <= 1'b0;
      k_init_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      blk_ready_q <= '0;
      k_init_q    <= 1'b0;
      k_resetn_q  <= 1'b1;
      error_q     <= 1'b0;
      if (abort_c || tmo_c) begin
        // Owner left or core hung: drop everything; the next grant clears the core.
        state_q      <= ST_IDLE;
        gnt_q        <= '0;
        hash_valid_q <= '0;
        k_enable_q   <= 1'b0;
        error_q      <= tmo_c;
      end else begin
        case (state_q)
          ST_IDLE: begin
            gnt_q        <= '0;
            hash_valid_q <= '0;
            k_enable_q   <= 1'b0;
            if (win_found) begin
              owner_q    <= win_idx;
              gnt_q      <= NUM_REQ'(1) << win_idx;
              rr_q       <= rr_d;
              k_resetn_q <= 1'b0;
              state_q    <= ST_CLEAR;
            end
          end
          ST_CLEAR: begin
            state_q <= ST_ABSORB;
          end
          ST_ABSORB: begin
            if (BLK_VALID[owner_q]) begin
              k_init_q    <= 1'b1;
              blk_ready_q <= NUM_REQ'(1) << owner_q;
              last_q      <= BLK_LAST[owner_q];
              state_q     <= ST_PERM;
            end
          end
          ST_PERM: begin
            if (K_DONE) begin
              k_enable_q <= 1'b0;
              if (last_q) begin
                hash_valid_q <= NUM_REQ'(1) << owner_q;
                state_q      <= ST_OUT;
              end else begin
                state_q <= ST_ABSORB;
              end
            end else begin
              k_enable_q <= 1'b1;
            end
          end
          ST_OUT: begin
            if (hs_c) begin
              gnt_q        <= '0;
              hash_valid_q <= '0;
              state_q      <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign GNT        = gnt_q;
  assign BLK_READY  = blk_ready_q;
  assign HASH_VALID = hash_valid_q;
  assign HASH_OUT   = K_OUT;
  assign K_RESETN   = k_resetn_q;
  assign K_ENABLE   = k_enable_q;
  assign K_INIT     = k_init_q;
  assign K_M        = BLK_DATA[32'(owner_q) * STATE_WIDTH +: STATE_WIDTH];
`ifdef KECCAK_ARB_TIMEOUT_EN
  assign ERROR      = error_q;
`else
  assign ERROR      = 1'b0;
`endif

endmodule

// File: tb/tb_keccak_arbiter.sv
// Testbench for keccak_arbiter: behavioural core model plus hash scoreboard.
module tb_keccak_arbiter;

  localparam int unsigned NR = 2;
  localparam int unsigned SW = 1600;

  typedef logic [SW-1:0] st_t;

  logic             CLK;
  logic             RESET;
  logic [NR-1:0]    REQ;
  logic [NR-1:0]    GNT;
  logic [NR-1:0]    BLK_VALID;
  logic [NR-1:0]    BLK_LAST;
  logic [NR*SW-1:0] BLK_DATA;
  logic [NR-1:0]    BLK_READY;
  logic [NR-1:0]    HASH_VALID;
  logic [NR-1:0]    HASH_READY;
  st_t              HASH_OUT;
  logic             ERROR;
  logic             K_RESETN;
  logic             K_ENABLE;
  logic             K_INIT;
  st_t              K_M;
  logic             K_DONE;
  st_t              K_OUT;

  keccak_arbiter #(.NUM_REQ(NR), .STATE_WIDTH(SW), .TIMEOUT(64)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(GNT),
    .BLK_VALID(BLK_VALID), .BLK_LAST(BLK_LAST), .BLK_DATA(BLK_DATA), .BLK_READY(BLK_READY),
    .HASH_VALID(HASH_VALID), .HASH_READY(HASH_READY), .HASH_OUT(HASH_OUT), .ERROR(ERROR),
    .K_RESETN(K_RESETN), .K_ENABLE(K_ENABLE), .K_INIT(K_INIT), .K_M(K_M),
    .K_DONE(K_DONE), .K_OUT(K_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Stand-in permutation: rotate left by one and mix in a constant.
  function automatic st_t perm_f(input st_t x);
    return {x[SW-2:0], x[SW-1]} ^ st_t'(64'hA5A5_0F0F_1234_5678);
  endfunction

  // Core model: sync clear, absorb on K_INIT, done after perm_len enabled cycles.
  int  perm_len  = 25;
  bit  core_live = 1'b1;
  st_t core_st;
  int  core_cnt;
  always @(negedge CLK) begin
    if (RESET || !K_RESETN) begin
      core_st  = '0;
      core_cnt = 0;
      K_DONE   = 1'b0;
    end else begin
      K_DONE = 1'b0;
      if (K_INIT) core_st = core_st ^ K_M;
      if (K_ENABLE) begin
        core_cnt++;
        if (core_live && core_cnt >= perm_len) begin
          K_DONE   = 1'b1;
          core_st  = perm_f(core_st);
          core_cnt = 0;
        end
      end
    end
    K_OUT = core_st;
  end

  // Event counters sampled mid-cycle.
  int kres_lows, kinit_cnt, blkr_cnt, hv_rise, illegal;
  logic [NR-1:0] hv_prev = '0;
  always @(negedge CLK) begin
    if (!RESET) begin
      if (!K_RESETN) kres_lows++;
      if (K_INIT) kinit_cnt++;
      if (|BLK_READY) blkr_cnt++;
      if (|(HASH_VALID & ~hv_prev)) hv_rise++;
      if (|(BLK_READY & ~GNT) || |(HASH_VALID & ~GNT)) illegal++;
    end
    hv_prev = HASH_VALID;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=hang required=finish");
    $fatal(1, "simulation time limit");
  end

  st_t           exp_q[$];
  logic [NR-1:0] gnt_exp_q[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hash(input string tag, input st_t obs, input st_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic clr_counts();
    kres_lows = 0; kinit_cnt = 0; blkr_cnt = 0; hv_rise = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b1; REQ = '0; BLK_VALID = '0; BLK_LAST = '0; HASH_READY = '0; BLK_DATA = '0;
    tick(); tick();
    RESET = 1'b0;
    tick();
  endtask

  function automatic st_t rand_blk();
    st_t b;
    for (int w = 0; w < int'(SW / 32); w++) b[w*32 +: 32] = $urandom;
    return b;
  endfunction

  // Present one block on requester r and wait for its BLK_READY; data held one more cycle.
  task automatic present(input int r, input st_t blk, input bit last);
    int n;
    BLK_DATA[r*SW +: SW] = blk;
    BLK_LAST[r]  = last;
    BLK_VALID[r] = 1'b1;
    for (n = 0; n < 300; n++) begin
      tick();
      if (BLK_READY[r]) break;
    end
    chk("blk_ready_seen", 64'(BLK_READY[r]), 64'd1);
    tick();
    BLK_VALID[r] = 1'b0;
  endtask

  // Full message from an already-granted owner; expected digest queued up front.
  task automatic send_msg(input int r, input int nblk, input bit drop);
    st_t blks[8];
    st_t e = '0;
    int  n;
    for (int b = 0; b < nblk; b++) begin
      blks[b] = rand_blk();
      e = perm_f(e ^ blks[b]);
    end
    exp_q.push_back(e);
    for (int b = 0; b < nblk; b++) present(r, blks[b], b == nblk - 1);
    for (n = 0; n < 300; n++) begin
      if (HASH_VALID[r]) break;
      tick();
    end
    chk("hash_valid_seen", 64'(HASH_VALID), 64'(NR'(1) << r));
    chk_hash("hash_out", HASH_OUT, exp_q.pop_front());
    HASH_READY[r] = 1'b1;
    if (drop) REQ[r] = 1'b0;
    tick();
    HASH_READY[r] = 1'b0;
  endtask

  initial begin
    logic [NR-1:0] g;
    int            r;
    int            n;

    // Reset values
    RESET = 1'b1; REQ = '0; BLK_VALID = '0; BLK_LAST = '0; HASH_READY = '0; BLK_DATA = '0;
    tick(); tick();
    chk("rst_gnt", 64'(GNT), 64'd0);
    chk("rst_blk_ready", 64'(BLK_READY), 64'd0);
    chk("rst_hash_valid", 64'(HASH_VALID), 64'd0);
    chk("rst_k_resetn", 64'(K_RESETN), 64'd0);
    chk("rst_k_enable", 64'(K_ENABLE), 64'd0);
    chk("rst_k_init", 64'(K_INIT), 64'd0);
    chk("rst_error", 64'(ERROR), 64'd0);
    RESET = 1'b0;
    tick();
    chk("idle_k_resetn", 64'(K_RESETN), 64'd1);

    // 1: single one-block message
    clr_counts();
    REQ = 2'b01;
    tick();
    chk("t1_gnt", 64'(GNT), 64'h1);
    chk("t1_k_resetn_clear", 64'(K_RESETN), 64'd0);
    send_msg(0, 1, 1'b1);
    chk("t1_gnt_after", 64'(GNT), 64'd0);
    chk("t1_kres_lows", 64'(kres_lows), 64'd1);
    chk("t1_kinit_cnt", 64'(kinit_cnt), 64'd1);
    chk("t1_hv_rise", 64'(hv_rise), 64'd1);

    // 2: both requesting from reset, grants alternate with one idle cycle between
    do_reset();
    gnt_exp_q.push_back(2'b01); gnt_exp_q.push_back(2'b10);
    gnt_exp_q.push_back(2'b01); gnt_exp_q.push_back(2'b10);
    REQ = 2'b11;
    tick();
    for (int m = 0; m < 4; m++) begin
      g = gnt_exp_q.pop_front();
      chk("t2_gnt", 64'(GNT), 64'(g));
      r = g[1] ? 1 : 0;
      if (m == 3) REQ[0] = 1'b0;
      send_msg(r, 1, m == 3);
      chk("t2_idle_gap", 64'(GNT), 64'd0);
      if (m < 3) tick();
    end

    // 3: three-block message
    clr_counts();
    REQ = 2'b01;
    tick();
    chk("t3_gnt", 64'(GNT), 64'h1);
    send_msg(0, 3, 1'b1);
    chk("t3_blkr_cnt", 64'(blkr_cnt), 64'd3);
    chk("t3_kinit_cnt", 64'(kinit_cnt), 64'd3);
    chk("t3_hv_rise", 64'(hv_rise), 64'd1);

    // 4: owner drops REQ mid-permutation, other requester follows with a clean core
    clr_counts();
    perm_len = 1000;
    REQ = 2'b01;
    tick();
    chk("t4_gnt0", 64'(GNT), 64'h1);
    REQ[1] = 1'b1;
    present(0, rand_blk(), 1'b1);
    repeat (5) tick();
    chk("t4_k_enable_perm", 64'(K_ENABLE), 64'd1);
    REQ[0] = 1'b0;
    tick();
    chk("t4_gnt_abort", 64'(GNT), 64'd0);
    chk("t4_k_enable_abort", 64'(K_ENABLE), 64'd0);
    chk("t4_hash_valid_abort", 64'(HASH_VALID), 64'd0);
    tick();
    chk("t4_gnt1", 64'(GNT), 64'h2);
    perm_len = 10;
    send_msg(1, 1, 1'b1);
    chk("t4_hv_rise", 64'(hv_rise), 64'd1);

    // 5: core never finishes
    core_live = 1'b0;
    REQ = 2'b01;
    tick();
    chk("t5_gnt", 64'(GNT), 64'h1);
    BLK_DATA[0 +: SW] = rand_blk();
    BLK_LAST[0] = 1'b1;
    BLK_VALID[0] = 1'b1;
    for (n = 0; n < 300; n++) begin
      tick();
      if (BLK_READY[0]) break;
    end
    chk("t5_blk_ready", 64'(BLK_READY[0]), 64'd1);
    n = 0;
`ifdef KECCAK_ARB_TIMEOUT_EN
    while (n < 200 && !ERROR) begin
      tick();
      n++;
      if (n == 1) BLK_VALID[0] = 1'b0;
    end
    chk("t5_error_delay", 64'(n), 64'd64);
    chk("t5_gnt_after", 64'(GNT), 64'd0);
    chk("t5_hash_valid", 64'(HASH_VALID), 64'd0);
    tick();
    chk("t5_error_pulse", 64'(ERROR), 64'd0);
    REQ = 2'b00;
`else
    while (n < 100) begin
      tick();
      n++;
      if (n == 1) BLK_VALID[0] = 1'b0;
      if (ERROR) break;
    end
    chk("t5_no_error", 64'(ERROR), 64'd0);
    chk("t5_still_perm", 64'(K_ENABLE), 64'd1);
    chk("t5_still_gnt", 64'(GNT), 64'h1);
    REQ = 2'b00;
    tick();
    chk("t5_gnt_release", 64'(GNT), 64'd0);
`endif
    tick();

    // 6: reset in PERM, then fresh grant
    REQ = 2'b01;
    tick();
    chk("t6_gnt0", 64'(GNT), 64'h1);
    present(0, rand_blk(), 1'b1);
    repeat (3) tick();
    chk("t6_k_enable_perm", 64'(K_ENABLE), 64'd1);
    REQ = 2'b10;
    RESET = 1'b1;
    #1;
    chk("t6_rst_gnt", 64'(GNT), 64'd0);
    chk("t6_rst_k_enable", 64'(K_ENABLE), 64'd0);
    chk("t6_rst_k_resetn", 64'(K_RESETN), 64'd0);
    chk("t6_rst_hash_valid", 64'(HASH_VALID), 64'd0);
    chk("t6_rst_blk_ready", 64'(BLK_READY), 64'd0);
    core_live = 1'b1;
    perm_len = 25;
    tick();
    RESET = 1'b0;
    tick();
    chk("t6_gnt1", 64'(GNT), 64'h2);
    send_msg(1, 1, 1'b1);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("no_nonowner_strobe", 64'(illegal), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
